im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//  Byte-stream program loader for the single-cycle CPU: writer side of the instruction ROM.
//  Receives a length-prefixed byte stream over a valid/ready link.
//  Packs the bytes MSB-first into 32-bit words and writes them into the IM write port.
//  Holds the CPU in reset (cpu_rstn) while a load is in progress; releases it on success.
// PARAMETERS
//  IM_AW      7    IM word-address width; capacity 2**IM_AW words
// PORTS
//  clk         in   1      system clock, rising edge
//  rstn        in   1      asynchronous, active-low reset
//  load_start  in   1      1-cycle pulse; begins a load (sampled in IDLE/DONE/ERR only)
//  byte_valid  in   1      byte_data valid
//  byte_data   in   8      stream byte
//  byte_ready  out  1      loader accepts byte this cycle (xfer = valid & ready)
//  im_we       out  1      IM write strobe, 1-cycle pulse
//  im_addr     out  IM_AW  IM word address
//  im_wdata    out  32     IM write data
//  cpu_rstn    out  1      CPU reset, active-low, registered
//  busy        out  1      load in progress
//  done        out  1      last load completed OK (sticky until next load_start)
//  err         out  1      last load failed (sticky until next load_start)
// BEHAVIOUR
//  Reset: state=IDLE; byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rstn=0, busy=0, done=0, err=0.
//  First clk after rstn release in IDLE: cpu_rstn -> 1.
//  Stream format: LEN_HI, LEN_LO (16-bit word count N), then 4*N data bytes, MSB first per word.
//  FSM states: IDLE, LEN_HI, LEN_LO, DATA, CKSUM, DONE, ERR.
//   IDLE/DONE/ERR --load_start--> LEN_HI; same edge: cpu_rstn=0, busy=1, done=0, err=0, im_addr=0.
//   LEN_HI --xfer--> LEN_LO.
//   LEN_LO --xfer--> DATA.
//    If N==0: skip DATA; go to CKSUM (macro on) or DONE.
//    If N>2**IM_AW: go to ERR.
//   DATA: byte counter 0..3. On the 4th xfer, the assembled word is presented next cycle with im_we=1, im_addr=word index.
//    Word index increments after each write and never wraps (N bounded above).
//    After word N's xfer: CKSUM (macro on) or DONE.
//   DONE: done=1, busy=0, cpu_rstn=1 (next edge).
//   ERR: err=1, busy=0, cpu_rstn stays 0.
//  byte_ready=1 only in LEN_HI/LEN_LO/DATA/CKSUM.
//   byte_valid while not ready: ignored, no stall of the FSM.
//  im_we pulse may coincide with the first byte of the next word; data path is one-cycle latency, so no back-pressure.
//  load_start while busy: ignored.
//  rstn asserted mid-load: immediate return to reset values; partial IM contents are left as written.
// CONFIGURATION
//  IM_LOADER_CKSUM_EN defined:
//   Byte-wise 8-bit sum S (mod 256) of all data bytes, excluding LEN bytes.
//   CKSUM state accepts one byte C: C==S -> DONE, else -> ERR (words already written remain).
//  Not defined: no CKSUM state; DONE directly after the last word; stream carries no trailer byte.
// STRUCTURE
//  Shared header im_loader_defs.vh: FSM state encodings (3-bit localparams), default IM_AW, stream byte-order constant.
//  Sub-module im_word_packer: 2-bit byte counter + 32-bit shift register.
//   Interfaces: in_valid/in_byte/clear; outputs word_valid pulse + word.
//  Top holds the FSM, length/index counters, checksum, and reset/status outputs.
//  sccomp integration: IM gains a write port (we/addr/wdata); CPU rstn = rstn & cpu_rstn at the top level.
// TESTING
//  1 Reset release, no load -> cpu_rstn 0 then 1 next edge; busy/done/err=0; byte_ready=0.
//  2 Stream 00 02 | 20 08 00 05 | 14 00 FF FF -> im_we at addr 0 data 0x20080005;
//    im_we at addr 1 data 0x1400FFFF; done=1; cpu_rstn=1; then reg_sel/reg_data runs bne program.
//  3 Same as 2 with byte_valid toggling every other cycle -> identical IM writes, just later.
//  4 LEN 00 81 with IM_AW=7 (N=129) -> ERR after LEN_LO; err=1; cpu_rstn=0; no im_we.
//  5 rstn low after 5 data bytes, then new load of 00 01 DE AD BE EF -> addr 0 = 0xDEADBEEF, done=1.
//  6 CKSUM_EN: 00 01 01 02 03 04 trailer 0A -> done.
//    Same with trailer 0B -> err=1; cpu_rstn held 0.

Source files
------------

// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared FSM encodings, default IM address width and stream byte order for the program loader.
`default_nettype none

package im_loader_pkg;

  localparam int IM_AW_DEFAULT = 7;

  // Words arrive most-significant byte first.
  localparam bit BYTE_MSB_FIRST = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CKSUM  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  function automatic logic [16:0] im_capacity(input int aw);
    return 17'd1 << aw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/im_loader_if.sv
// im_loader_if: byte-stream link, IM write port and CPU reset/status bundle of the program loader.
`default_nettype none

interface im_loader_if #(
  parameter int IM_AW = 7
) ();

  logic             load_start;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_wdata;
  logic             cpu_rstn;
  logic             busy;
  logic             done;
  logic             err;

  // Stream source / status observer side.
  modport master (
    output load_start, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_rstn, busy, done, err
  );

  // Loader side.
  modport slave (
    input  load_start, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_rstn, busy, done, err
  );

endinterface

`default_nettype wire

// File: rtl/im_word_packer.sv
// im_word_packer: collects four stream bytes into one 32-bit word and pulses word_valid_o the cycle after the 4th byte.
`default_nettype none

module im_word_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic        last_byte_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clear_i) begin
        cnt_q  <= 2'd0;
        word_q <= 32'd0;
      end else if (in_valid_i) begin
        cnt_q   <= cnt_q + 2'd1;
        word_q  <= BYTE_MSB_FIRST ? {word_q[23:0], in_byte_i} : {in_byte_i, word_q[31:8]};
        valid_q <= (cnt_q == 2'd3);
      end
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;
  assign last_byte_o  = (cnt_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
// im_loader: length-prefixed byte-stream loader writing 32-bit words into the IM and holding the CPU in reset meanwhile.
// Define IM_LOADER_CKSUM_EN to require a trailing 8-bit sum-of-data-bytes check before DONE.
`default_nettype none

module im_loader
  import im_loader_pkg::*;
#(
  parameter int IM_AW = IM_AW_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  im_loader_if.slave bus
);

  localparam logic [16:0] CAPACITY = im_capacity(IM_AW);
`ifdef IM_LOADER_CKSUM_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_CKSUM;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

  logic [2:0]       state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      words_q, words_d;
  logic [IM_AW-1:0] addr_q, addr_d;
  logic             cpu_rstn_q, cpu_rstn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef IM_LOADER_CKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  logic        ready;
  logic        xfer;
  logic        start;
  logic        last_byte;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len_w;
  logic [15:0] words_inc;

  assign ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                 (state_q == ST_DATA)   || (state_q == ST_CKSUM);
  assign xfer  = bus.byte_valid & ready;
  assign start = bus.load_start &
                 ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign len_w     = {len_hi_q, bus.byte_data};
  assign words_inc = words_q + 16'd1;

  im_word_packer u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .clear_i      (start),
    .in_valid_i   (xfer && (state_q == ST_DATA)),
    .in_byte_i    (bus.byte_data),
    .word_valid_o (word_valid),
    .word_o       (word),
    .last_byte_o  (last_byte)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    words_d    = words_q;
    addr_d     = addr_q;
    cpu_rstn_d = cpu_rstn_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef IM_LOADER_CKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: cpu_rstn_d = 1'b1;
      ST_LEN_HI: begin
        if (xfer) begin
          len_hi_d = bus.byte_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d   = len_w;
          words_d = 16'd0;
          if (len_w == 16'd0)                  state_d = ST_AFTER_DATA;
          else if ({1'b0, len_w} > CAPACITY)   state_d = ST_ERR;
          else                                 state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
`ifdef IM_LOADER_CKSUM_EN
          sum_d = sum_q + bus.byte_data;
`endif
          if (last_byte) begin
            words_d = words_inc;
            if (words_inc == len_q) state_d = ST_AFTER_DATA;
          end
        end
      end
`ifdef IM_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (xfer) state_d = (bus.byte_data == sum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: ;
    endcase

    if ((state_d != state_q) && ((state_d == ST_DONE) || (state_d == ST_ERR))) begin
      busy_d = 1'b0;
      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERR);
    end

    // Saturate rather than wrap; only the final write of a full-capacity load reaches the top.
    if (word_valid && (addr_q != {IM_AW{1'b1}})) addr_d = addr_q + 1'b1;

    if (start) begin
      state_d    = ST_LEN_HI;
      cpu_rstn_d = 1'b0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b0;
      addr_d     = '0;
`ifdef IM_LOADER_CKSUM_EN
      sum_d      = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      len_hi_q   <= 8'd0;
      len_q      <= 16'd0;
      words_q    <= 16'd0;
      addr_q     <= '0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IM_LOADER_CKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      cpu_rstn_q <= cpu_rstn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IM_LOADER_CKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.byte_ready = ready;
  assign bus.im_we      = word_valid;
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = word;
  assign bus.cpu_rstn   = cpu_rstn_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// tb_im_loader: directed table-driven bench for im_loader with hand-written multi-cycle sequences.
`default_nettype none

module tb_im_loader;

  localparam int AW = 7;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  im_loader_if #(.IM_AW(AW)) bus ();

  im_loader #(.IM_AW(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  logic [7:0]    sum;

  always @(negedge clk) begin
    if (rstn && bus.im_we) begin
      wa.push_back(bus.im_addr);
      wd.push_back(bus.im_wdata);
    end
  end

  typedef struct {
    logic [95:0] bytes;
    int          nb;
    bit          toggle;
    bit          exp_done;
    int          nwr;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit toggle, input bit is_data);
    int n = 0;
    if (toggle) @(negedge clk);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("byte_ready_timeout", 32'd0, 32'd1);
    if (is_data) sum = sum + b;
    @(posedge clk);
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [95:0] b, input int nb, input bit toggle);
    for (int k = 0; k < nb; k++) send_byte(b[8*(11-k) +: 8], toggle, k >= 2);
  endtask

  task automatic send_trailer();
`ifdef IM_LOADER_CKSUM_EN
    send_byte(sum, 1'b0, 1'b0);
`endif
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    sum = 8'd0;
    wa.delete();
    wd.delete();
    check({tag, "_busy_at_start"}, bus.busy, 32'd1);
    check({tag, "_cpu_rstn_at_start"}, bus.cpu_rstn, 32'd0);
  endtask

  task automatic wait_end(input string tag, input bit exp_done, input int nwr);
    int n = 0;
    while (!(bus.done || bus.err) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_end_timeout"}, (n < 100) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done"}, bus.done, exp_done);
    check({tag, "_err"}, bus.err, !exp_done);
    check({tag, "_cpu_rstn"}, bus.cpu_rstn, exp_done);
    check({tag, "_busy"}, bus.busy, 32'd0);
    check({tag, "_nwrites"}, wa.size(), nwr);
  endtask

  task automatic check_wr(input string tag, input int j, input logic [31:0] exp_data);
    if (j < wa.size()) begin
      check($sformatf("%s_addr%0d", tag, j), wa[j], j);
      check($sformatf("%s_data%0d", tag, j), wd[j], exp_data);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 8'h5A, b ^ 8'h33};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;

    vecs[0] = '{96'h0002_2008_0005_1400_FFFF_0000, 10, 1'b0, 1'b1, 2, 32'h20080005, 32'h1400FFFF};
    vecs[1] = '{96'h0002_2008_0005_1400_FFFF_0000, 10, 1'b1, 1'b1, 2, 32'h20080005, 32'h1400FFFF};
    vecs[2] = '{96'h0081_0000_0000_0000_0000_0000,  2, 1'b0, 1'b0, 0, 32'h0, 32'h0};
    vecs[3] = '{96'h0000_0000_0000_0000_0000_0000,  2, 1'b1, 1'b1, 0, 32'h0, 32'h0};

    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    sum            = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_cpu_rstn", bus.cpu_rstn, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_done", bus.done, 32'd0);
    check("rst_err", bus.err, 32'd0);
    check("rst_byte_ready", bus.byte_ready, 32'd0);
    check("rst_im_we", bus.im_we, 32'd0);
    check("rst_im_addr", bus.im_addr, 32'd0);
    check("rst_im_wdata", bus.im_wdata, 32'd0);

    rstn = 1'b1;
    #1 check("cpu_rstn_before_edge", bus.cpu_rstn, 32'd0);
    @(negedge clk);
    check("cpu_rstn_after_edge", bus.cpu_rstn, 32'd1);

    // Stray stream bytes while idle must not start anything.
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    bus.byte_valid = 1'b0;
    check("idle_junk_busy", bus.busy, 32'd0);
    check("idle_junk_ready", bus.byte_ready, 32'd0);
    check("idle_junk_writes", wa.size(), 32'd0);

    for (int i = 0; i < 4; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      pulse_start(tag);
      send_seq(vecs[i].bytes, vecs[i].nb, vecs[i].toggle);
      if (vecs[i].exp_done) send_trailer();
      wait_end(tag, vecs[i].exp_done, vecs[i].nwr);
      if (vecs[i].nwr > 0) check_wr(tag, 0, vecs[i].d0);
      if (vecs[i].nwr > 1) check_wr(tag, 1, vecs[i].d1);
    end

    // load_start while a load is running is ignored.
    pulse_start("busy_start");
    send_seq(96'h0001_AABB_0000_0000_0000_0000, 4, 1'b0);
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    check("busy_start_still_busy", bus.busy, 32'd1);
    send_byte(8'hCC, 1'b0, 1'b1);
    send_byte(8'hDD, 1'b0, 1'b1);
    send_trailer();
    wait_end("busy_start", 1'b1, 1);
    check_wr("busy_start", 0, 32'hAABBCCDD);

    // Reset mid-load, then a fresh load.
    pulse_start("midrst");
    send_seq(96'h0002_1122_3344_5500_0000_0000, 7, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 32'd0);
    check("midrst_ready", bus.byte_ready, 32'd0);
    check("midrst_cpu_rstn", bus.cpu_rstn, 32'd0);
    check("midrst_addr", bus.im_addr, 32'd0);
    check("midrst_partial_writes", wa.size(), 32'd1);
    check("midrst_partial_data", (wd.size() > 0) ? wd[0] : 32'hX, 32'h11223344);
    @(negedge clk);
    rstn = 1'b1;
    pulse_start("reload");
    send_seq(96'h0001_DEAD_BEEF_0000_0000_0000, 6, 1'b0);
    send_trailer();
    wait_end("reload", 1'b1, 1);
    check_wr("reload", 0, 32'hDEADBEEF);

    // Full-capacity load: N == 2**IM_AW is accepted.
    pulse_start("nmax");
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 128; i++) begin
      w = word_of(i);
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 1'b0, 1'b1);
    end
    send_trailer();
    wait_end("nmax", 1'b1, 128);
    for (int j = 0; j < 128; j++) check_wr("nmax", j, word_of(j));

`ifdef IM_LOADER_CKSUM_EN
    pulse_start("ck_ok");
    send_seq(96'h0001_0102_0304_0A00_0000_0000, 7, 1'b0);
    wait_end("ck_ok", 1'b1, 1);
    check_wr("ck_ok", 0, 32'h01020304);

    pulse_start("ck_bad");
    send_seq(96'h0001_0102_0304_0B00_0000_0000, 7, 1'b0);
    wait_end("ck_bad", 1'b0, 1);
    check_wr("ck_bad", 0, 32'h01020304);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
